// File: rtl/hdmi_link_supervisor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdmi_link_supervisor_if                                              |
// | Decoder status inputs and supervisor outputs of the HDMI link.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface hdmi_link_supervisor_if;
  logic       hdmi_valid;
  logic       vsync;
  logic       user_reset;
  logic       hdmi_reset;
  logic       link_up;
  logic [7:0] retry_count;
  logic [7:0] frame_count;

  modport master (
    output hdmi_valid, vsync, user_reset,
    input  hdmi_reset, link_up, retry_count, frame_count
  );

  modport slave (
    input  hdmi_valid, vsync, user_reset,
    output hdmi_reset, link_up, retry_count, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/hdmi_link_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hdmi_link_supervisor                                                 |
// | Watches the TMDS decoder valid flag, pulses the decoder reset on     |
// | persistent loss, reports lock and counts frames.                     |
// | Optional macro: WRANGLER_LINK_BACKOFF_EN (exponential holdoff).      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hdmi_link_supervisor #(
  parameter int CNT_WIDTH         = 21,
  parameter int RESET_CYCLES      = 16,
  parameter int HOLDOFF_CYCLES    = 1024,
  parameter int LOCK_CYCLES       = 4096,
  parameter int MAX_BACKOFF_SHIFT = 4,
  parameter int TIMER_WIDTH       = 20
) (
  input wire logic        clk,
  input wire logic        reset,
  hdmi_link_supervisor_if.slave link
);

  localparam logic [1:0] ST_MONITOR = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [GOOD_W-1:0]      GOOD_MAX   = GOOD_W'(LOCK_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] PULSE_LOAD = TIMER_WIDTH'(RESET_CYCLES - 1);

  logic                   valid_meta_q, valid_s_q;
  logic                   vsync_meta_q, vsync_s_q, vsync_prev_q;
  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   bad_cnt_q, bad_cnt_d;
  logic [GOOD_W-1:0]      good_cnt_q, good_cnt_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [TIMER_WIDTH-1:0] holdoff_load;
  logic                   hdmi_reset_q, hdmi_reset_d;
  logic                   link_up_q, link_up_d;
  logic [7:0]             retry_count_q, retry_count_d;
  logic [7:0]             frame_count_q, frame_count_d;
  logic                   pulse_entry, holdoff_entry, link_rise, vsync_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_meta_q <= 1'b0;
      valid_s_q    <= 1'b0;
      vsync_meta_q <= 1'b0;
      vsync_s_q    <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      valid_meta_q <= link.hdmi_valid;
      valid_s_q    <= valid_meta_q;
      vsync_meta_q <= link.vsync;
      vsync_s_q    <= vsync_meta_q;
      vsync_prev_q <= vsync_s_q;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_MONITOR;
    else       state_q <= state_d;
  end

  // Next-state logic; user_reset wins over the timer in every state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MONITOR: begin
        if (link.user_reset || bad_cnt_q[CNT_WIDTH-1]) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (!link.user_reset && (timer_q == '0)) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (link.user_reset)      state_d = ST_PULSE;
        else if (timer_q == '0)   state_d = ST_MONITOR;
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  // Output logic: the reset flop follows the next state, so it is glitch-free
  always_comb begin
    hdmi_reset_d  = (state_d == ST_PULSE);
    pulse_entry   = (state_d == ST_PULSE)   && (state_q != ST_PULSE);
    holdoff_entry = (state_d == ST_HOLDOFF) && (state_q != ST_HOLDOFF);
  end

`ifdef WRANGLER_LINK_BACKOFF_EN
  localparam int SHIFT_W = (MAX_BACKOFF_SHIFT > 0) ? $clog2(MAX_BACKOFF_SHIFT + 1) : 1;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(MAX_BACKOFF_SHIFT);

  logic [SHIFT_W-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (link_rise)                                  shift_d = '0;
    else if (holdoff_entry && (shift_q != SHIFT_MAX)) shift_d = shift_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shift_q <= '0;
    else       shift_q <= shift_d;
  end

  assign holdoff_load = (TIMER_WIDTH'(HOLDOFF_CYCLES) << shift_q) - TIMER_WIDTH'(1);
`else
  assign holdoff_load = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);
`endif

  always_comb begin
    timer_d = timer_q;
    if (pulse_entry || ((state_q == ST_PULSE) && link.user_reset))
      timer_d = PULSE_LOAD;
    else if (holdoff_entry)
      timer_d = holdoff_load;
    else if ((state_q != ST_MONITOR) && (timer_q != '0))
      timer_d = timer_q - 1'b1;

    bad_cnt_d = bad_cnt_q;
    if (holdoff_entry)
      bad_cnt_d = '0;
    else if (state_q == ST_MONITOR) begin
      if (valid_s_q) begin
        if (bad_cnt_q != '0) bad_cnt_d = bad_cnt_q - 1'b1;
      end else begin
        if (bad_cnt_q != '1) bad_cnt_d = bad_cnt_q + 1'b1;
      end
    end

    // Lock needs an unbroken run of valid cycles inside MONITOR
    good_cnt_d = '0;
    if ((state_q == ST_MONITOR) && (state_d == ST_MONITOR) && valid_s_q)
      good_cnt_d = (good_cnt_q == GOOD_MAX) ? good_cnt_q : good_cnt_q + 1'b1;

    link_up_d = (good_cnt_d == GOOD_MAX);
    link_rise = link_up_d && !link_up_q;

    retry_count_d = retry_count_q;
    if (link_rise)
      retry_count_d = 8'd0;
    else if (pulse_entry && (retry_count_q != 8'hFF))
      retry_count_d = retry_count_q + 8'd1;

    vsync_fall    = vsync_prev_q && !vsync_s_q;
    frame_count_d = frame_count_q;
    if (link_up_q && vsync_fall)
      frame_count_d = frame_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_cnt_q     <= '0;
      good_cnt_q    <= '0;
      timer_q       <= '0;
      hdmi_reset_q  <= 1'b0;
      link_up_q     <= 1'b0;
      retry_count_q <= 8'd0;
      frame_count_q <= 8'd0;
    end else begin
      bad_cnt_q     <= bad_cnt_d;
      good_cnt_q    <= good_cnt_d;
      timer_q       <= timer_d;
      hdmi_reset_q  <= hdmi_reset_d;
      link_up_q     <= link_up_d;
      retry_count_q <= retry_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign link.hdmi_reset  = hdmi_reset_q;
  assign link.link_up     = link_up_q;
  assign link.retry_count = retry_count_q;
  assign link.frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_link_supervisor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hdmi_link_supervisor                                              |
// | Directed scoreboard bench for hdmi_link_supervisor.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hdmi_link_supervisor;
  localparam int CNT_WIDTH         = 4;
  localparam int RESET_CYCLES      = 4;
  localparam int HOLDOFF_CYCLES    = 8;
  localparam int LOCK_CYCLES       = 16;
  localparam int MAX_BACKOFF_SHIFT = 4;
  localparam int TIMER_WIDTH       = 20;
  localparam int BUDGET            = 1000;
  localparam int TRIP              = (1 << (CNT_WIDTH - 1)) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  hdmi_link_supervisor_if link();

  hdmi_link_supervisor #(
    .CNT_WIDTH        (CNT_WIDTH),
    .RESET_CYCLES     (RESET_CYCLES),
    .HOLDOFF_CYCLES   (HOLDOFF_CYCLES),
    .LOCK_CYCLES      (LOCK_CYCLES),
    .MAX_BACKOFF_SHIFT(MAX_BACKOFF_SHIFT),
    .TIMER_WIDTH      (TIMER_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .link (link)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_q[$];
  string tag_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input int v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0d expected none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", t, obs, e);
    end
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    while (!link.hdmi_reset && n < BUDGET) begin tick(); n++; end
  endtask

  task automatic measure_width(output int n);
    n = 0;
    while (link.hdmi_reset && n < BUDGET) begin tick(); n++; end
  endtask

  task automatic wait_link(input logic level, output int n);
    n = 0;
    while ((link.link_up !== level) && n < BUDGET) begin tick(); n++; end
  endtask

  function automatic int holdoff_of(input int i);
`ifdef WRANGLER_LINK_BACKOFF_EN
    return HOLDOFF_CYCLES << ((i < MAX_BACKOFF_SHIFT) ? i : MAX_BACKOFF_SHIFT);
`else
    return HOLDOFF_CYCLES;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int highs;
    logic seen_reset, seen_link;

    link.hdmi_valid = 1'b0;
    link.vsync      = 1'b0;
    link.user_reset = 1'b0;
    reset           = 1'b1;
    repeat (3) tick();

    expect_val("rst_hdmi_reset", 0);  check(link.hdmi_reset);
    expect_val("rst_link_up", 0);     check(link.link_up);
    expect_val("rst_retry", 0);       check(link.retry_count);
    expect_val("rst_frame", 0);       check(link.frame_count);

    // Persistent invalid: trip, pulse, holdoff, repeat
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expect_val($sformatf("gap_%0d", i), (i == 0) ? TRIP : holdoff_of(i - 1) + TRIP);
      measure_gap(n);   check(n);
      expect_val($sformatf("pulse_width_%0d", i), RESET_CYCLES);
      measure_width(n); check(n);
      expect_val($sformatf("retry_%0d", i), i + 1);
      check(link.retry_count);
    end

    // Valid arrives at the start of the last holdoff
    link.hdmi_valid = 1'b1;
    expect_val("lock_after_holdoff", holdoff_of(6) + LOCK_CYCLES);
    wait_link(1'b1, n); check(n);
    expect_val("retry_clear_on_lock", 0); check(link.retry_count);

    // Single-cycle valid drop
    link.hdmi_valid = 1'b0;
    tick();
    link.hdmi_valid = 1'b1;
    expect_val("drop_still_up", 1); check(link.link_up);
    wait_link(1'b0, n);
    expect_val("drop_latency", 3); check(n + 1);
    expect_val("relock", LOCK_CYCLES); wait_link(1'b1, n); check(n);
    expect_val("frame_before", 0); check(link.frame_count);

    for (int i = 0; i < 300; i++) begin
      link.vsync = 1'b1; tick();
      link.vsync = 1'b0; tick();
    end
    repeat (4) tick();
    expect_val("frame_wrap", 300 % 256); check(link.frame_count);
    expect_val("link_during_frames", 1); check(link.link_up);

    link.hdmi_valid = 1'b0;
    repeat (4) tick();
    expect_val("link_down", 0); check(link.link_up);
    for (int i = 0; i < 5; i++) begin
      link.vsync = 1'b1; tick();
      link.vsync = 1'b0; tick();
    end
    repeat (4) tick();
    expect_val("frame_no_count_unlocked", 300 % 256); check(link.frame_count);

    // Toggling valid never trips and never locks
    reset = 1'b1; tick(); reset = 1'b0;
    expect_val("frame_after_reset", 0); check(link.frame_count);
    seen_reset = 1'b0;
    seen_link  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      link.hdmi_valid = ~link.hdmi_valid;
      tick();
      if (link.hdmi_reset) seen_reset = 1'b1;
      if (link.link_up)    seen_link  = 1'b1;
    end
    expect_val("toggle_no_reset", 0); check(seen_reset);
    expect_val("toggle_no_link", 0);  check(seen_link);

    // user_reset again in the second pulse cycle stretches the pulse
    reset = 1'b1; tick();
    link.hdmi_valid = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    highs = 0;
    for (int i = 1; i <= 12; i++) begin
      link.user_reset = (i == 1) || (i == 3);
      tick();
      if (link.hdmi_reset) highs++;
    end
    link.user_reset = 1'b0;
    expect_val("user_pulse_width", RESET_CYCLES + 2); check(highs);
    expect_val("user_retry", 1); check(link.retry_count);
    expect_val("holdoff_low", 0); check(link.hdmi_reset);

    // Async reset mid-holdoff clears everything without a clock
    #2 reset = 1'b1;
    #1;
    expect_val("async_rst_outputs", 0);
    check({link.hdmi_reset, link.link_up, link.retry_count, link.frame_count});

    // Async reset mid-pulse abandons the pulse
    reset = 1'b0;
    tick();
    link.user_reset = 1'b1; tick(); link.user_reset = 1'b0;
    expect_val("pulse_started", 1); check(link.hdmi_reset);
    #2 reset = 1'b1;
    #1;
    expect_val("pulse_killed", 0); check(link.hdmi_reset);
    tick(); tick();
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (link.hdmi_reset) highs++;
    end
    expect_val("no_resumed_pulse", 0); check(highs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
